// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite memory arbiter.
package axi_arb_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t RD_ADDR = 3'd1;
  localparam state_t RD_DATA = 3'd2;
  localparam state_t WR_REQ  = 3'd3;
  localparam state_t WR_RESP = 3'd4;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  localparam logic [2:0] PROT_INSN = 3'b100;
  localparam logic [2:0] PROT_DATA = 3'b000;

endpackage

// File: rtl/axi_lite_mem_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter: IFU (read-only) and LSU
// (read/write) share the memory port, one transaction in flight at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | pick a requester; drain stray R/B responses
// RD_ADDR | mem_axi_arvalid high, waiting for arready
// RD_DATA | forward R channel to the owner, wait for R handshake
// WR_REQ  | awvalid/wvalid each held until their own handshake
// WR_RESP | forward B channel to the LSU, wait for B handshake
module axi_lite_mem_arbiter
  import axi_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            ifu_axi_arvalid,
  input  logic            ifu_axi_rready,
  input  logic [AW-1:0]   ifu_axi_araddr,
  output logic            ifu_axi_arready,
  output logic            ifu_axi_rvalid,
  output logic [DW-1:0]   ifu_axi_rdata,

  input  logic            lsu_axi_arvalid,
  input  logic            lsu_axi_rready,
  input  logic [AW-1:0]   lsu_axi_araddr,
  input  logic [AW-1:0]   lsu_axi_awaddr,
  input  logic            lsu_axi_awvalid,
  input  logic            lsu_axi_wvalid,
  input  logic            lsu_axi_bready,
  input  logic [DW-1:0]   lsu_axi_wdata,
  input  logic [DW/8-1:0] lsu_axi_wstrb,
  output logic            lsu_axi_arready,
  output logic            lsu_axi_rvalid,
  output logic            lsu_axi_awready,
  output logic            lsu_axi_wready,
  output logic            lsu_axi_bvalid,
  output logic [DW-1:0]   lsu_axi_rdata,

  output logic            mem_axi_arvalid,
  output logic            mem_axi_awvalid,
  output logic            mem_axi_wvalid,
  output logic            mem_axi_rready,
  output logic            mem_axi_bready,
  output logic [AW-1:0]   mem_axi_araddr,
  output logic [AW-1:0]   mem_axi_awaddr,
  output logic [2:0]      mem_axi_arprot,
  output logic [2:0]      mem_axi_awprot,
  output logic [DW-1:0]   mem_axi_wdata,
  output logic [DW/8-1:0] mem_axi_wstrb,
  input  logic            mem_axi_arready,
  input  logic            mem_axi_awready,
  input  logic            mem_axi_wready,
  input  logic            mem_axi_rvalid,
  input  logic            mem_axi_bvalid,
  input  logic [DW-1:0]   mem_axi_rdata
);

  state_t          state;
  owner_t          owner;
  owner_t          rr_last;
  logic [AW-1:0]   ar_addr_q;
  logic [2:0]      ar_prot_q;
  logic [AW-1:0]   aw_addr_q;
  logic [DW-1:0]   w_data_q;
  logic [DW/8-1:0] w_strb_q;
  logic            arvalid_q;
  logic            awvalid_q;
  logic            wvalid_q;

  logic is_idle;
  logic grant_wr;
  logic grant_ifu;
  logic grant_lsu_rd;
  logic aw_fire;
  logic w_fire;
  logic aw_done;
  logic w_done;
  logic r_fire;
  logic b_fire;

  // Pick logic: a complete LSU write wins; reads round-robin when both ask.
  always_comb begin
    is_idle      = (state == IDLE);
    grant_wr     = lsu_axi_awvalid && lsu_axi_wvalid;
    grant_ifu    = !grant_wr && ifu_axi_arvalid &&
                   (!lsu_axi_arvalid || rr_last == OWN_LSU);
    grant_lsu_rd = !grant_wr && lsu_axi_arvalid &&
                   (!ifu_axi_arvalid || rr_last == OWN_IFU);
  end

  assign ifu_axi_arready = is_idle && grant_ifu;
  assign lsu_axi_arready = is_idle && grant_lsu_rd;
  assign lsu_axi_awready = is_idle && grant_wr;
  assign lsu_axi_wready  = is_idle && grant_wr;

  assign aw_fire = awvalid_q && mem_axi_awready;
  assign w_fire  = wvalid_q && mem_axi_wready;
  assign aw_done = !awvalid_q || aw_fire;
  assign w_done  = !wvalid_q || w_fire;
  assign r_fire  = mem_axi_rvalid && mem_axi_rready;
  assign b_fire  = mem_axi_bvalid && mem_axi_bready;

  // Response routing; IDLE accepts anything so orphaned responses are dropped.
  always_comb begin
    mem_axi_rready = 1'b0;
    mem_axi_bready = 1'b0;
    if (is_idle) begin
      mem_axi_rready = 1'b1;
      mem_axi_bready = 1'b1;
    end else if (state == RD_DATA) begin
      mem_axi_rready = (owner == OWN_IFU) ? ifu_axi_rready : lsu_axi_rready;
    end else if (state == WR_RESP) begin
      mem_axi_bready = lsu_axi_bready;
    end
  end

  assign ifu_axi_rvalid = (state == RD_DATA) && (owner == OWN_IFU) && mem_axi_rvalid;
  assign lsu_axi_rvalid = (state == RD_DATA) && (owner == OWN_LSU) && mem_axi_rvalid;
  assign ifu_axi_rdata  = mem_axi_rdata;
  assign lsu_axi_rdata  = mem_axi_rdata;
  assign lsu_axi_bvalid = (state == WR_RESP) && mem_axi_bvalid;

  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_araddr  = ar_addr_q;
  assign mem_axi_arprot  = ar_prot_q;
  assign mem_axi_awaddr  = aw_addr_q;
  assign mem_axi_awprot  = PROT_DATA;
  assign mem_axi_wdata   = w_data_q;
  assign mem_axi_wstrb   = w_strb_q;

  // Transaction FSM; latched request fields hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IFU;
      rr_last   <= OWN_LSU;
      ar_addr_q <= '0;
      ar_prot_q <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            aw_addr_q <= lsu_axi_awaddr;
            w_data_q  <= lsu_axi_wdata;
            w_strb_q  <= lsu_axi_wstrb;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            owner     <= OWN_LSU;
            state     <= WR_REQ;
          end else if (grant_ifu) begin
            ar_addr_q <= ifu_axi_araddr;
            ar_prot_q <= PROT_INSN;
            arvalid_q <= 1'b1;
            owner     <= OWN_IFU;
            rr_last   <= OWN_IFU;
            state     <= RD_ADDR;
          end else if (grant_lsu_rd) begin
            ar_addr_q <= lsu_axi_araddr;
            ar_prot_q <= PROT_DATA;
            arvalid_q <= 1'b1;
            owner     <= OWN_LSU;
            rr_last   <= OWN_LSU;
            state     <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (mem_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_fire) state <= IDLE;
        end
        WR_REQ: begin
          if (aw_fire) awvalid_q <= 1'b0;
          if (w_fire)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) state <= WR_RESP;
        end
        WR_RESP: begin
          if (b_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter; the bench plays the memory slave.
module tb_axi_lite_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_axi_arvalid, ifu_axi_rready, ifu_axi_arready, ifu_axi_rvalid;
  logic [31:0] ifu_axi_araddr, ifu_axi_rdata;
  logic        lsu_axi_arvalid, lsu_axi_rready, lsu_axi_awvalid, lsu_axi_wvalid, lsu_axi_bready;
  logic [31:0] lsu_axi_araddr, lsu_axi_awaddr, lsu_axi_wdata, lsu_axi_rdata;
  logic [3:0]  lsu_axi_wstrb;
  logic        lsu_axi_arready, lsu_axi_rvalid, lsu_axi_awready, lsu_axi_wready, lsu_axi_bvalid;
  logic        mem_axi_arvalid, mem_axi_awvalid, mem_axi_wvalid, mem_axi_rready, mem_axi_bready;
  logic [31:0] mem_axi_araddr, mem_axi_awaddr, mem_axi_wdata, mem_axi_rdata;
  logic [2:0]  mem_axi_arprot, mem_axi_awprot;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_arready, mem_axi_awready, mem_axi_wready, mem_axi_rvalid, mem_axi_bvalid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_lite_mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_axi_arvalid(ifu_axi_arvalid), .ifu_axi_rready(ifu_axi_rready),
    .ifu_axi_araddr(ifu_axi_araddr), .ifu_axi_arready(ifu_axi_arready),
    .ifu_axi_rvalid(ifu_axi_rvalid), .ifu_axi_rdata(ifu_axi_rdata),
    .lsu_axi_arvalid(lsu_axi_arvalid), .lsu_axi_rready(lsu_axi_rready),
    .lsu_axi_araddr(lsu_axi_araddr), .lsu_axi_awaddr(lsu_axi_awaddr),
    .lsu_axi_awvalid(lsu_axi_awvalid), .lsu_axi_wvalid(lsu_axi_wvalid),
    .lsu_axi_bready(lsu_axi_bready), .lsu_axi_wdata(lsu_axi_wdata),
    .lsu_axi_wstrb(lsu_axi_wstrb), .lsu_axi_arready(lsu_axi_arready),
    .lsu_axi_rvalid(lsu_axi_rvalid), .lsu_axi_awready(lsu_axi_awready),
    .lsu_axi_wready(lsu_axi_wready), .lsu_axi_bvalid(lsu_axi_bvalid),
    .lsu_axi_rdata(lsu_axi_rdata),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_awvalid(mem_axi_awvalid),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_bready(mem_axi_bready), .mem_axi_araddr(mem_axi_araddr),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_awprot(mem_axi_awprot), .mem_axi_wdata(mem_axi_wdata),
    .mem_axi_wstrb(mem_axi_wstrb), .mem_axi_arready(mem_axi_arready),
    .mem_axi_awready(mem_axi_awready), .mem_axi_wready(mem_axi_wready),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_bvalid(mem_axi_bvalid),
    .mem_axi_rdata(mem_axi_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ifu_axi_arvalid = 0; ifu_axi_rready = 0; ifu_axi_araddr = '0;
    lsu_axi_arvalid = 0; lsu_axi_rready = 0; lsu_axi_araddr = '0;
    lsu_axi_awvalid = 0; lsu_axi_wvalid = 0; lsu_axi_bready = 0;
    lsu_axi_awaddr = '0; lsu_axi_wdata = '0; lsu_axi_wstrb = '0;
    mem_axi_arready = 0; mem_axi_awready = 0; mem_axi_wready = 0;
    mem_axi_rvalid = 0; mem_axi_bvalid = 0; mem_axi_rdata = '0;

    // Reset state
    cyc(); cyc(); rst = 1'b0; settle();
    chk("rst_arvalid", mem_axi_arvalid, 1'b0);
    chk("rst_awvalid", mem_axi_awvalid, 1'b0);
    chk("rst_wvalid", mem_axi_wvalid, 1'b0);
    chk("rst_araddr", mem_axi_araddr, 32'h0);
    chk("rst_wdata", mem_axi_wdata, 32'h0);
    chk("rst_ifu_arready", ifu_axi_arready, 1'b0);
    chk("rst_ifu_rvalid", ifu_axi_rvalid, 1'b0);
    chk("rst_idle_rready", mem_axi_rready, 1'b1);
    chk("rst_idle_bready", mem_axi_bready, 1'b1);

    // IFU read 0x8000_0000, arready after 2 cycles, rready held low 3 cycles
    cyc(); ifu_axi_arvalid = 1; ifu_axi_araddr = 32'h8000_0000; settle();
    chk("t1_ifu_arready", ifu_axi_arready, 1'b1);
    chk("t1_arvalid_pre", mem_axi_arvalid, 1'b0);
    cyc(); ifu_axi_arvalid = 0; ifu_axi_araddr = 32'hdead_beef; settle();
    chk("t1_arvalid", mem_axi_arvalid, 1'b1);
    chk("t1_araddr", mem_axi_araddr, 32'h8000_0000);
    chk("t1_arprot", mem_axi_arprot, 3'b100);
    chk("t1_ifu_arready_busy", ifu_axi_arready, 1'b0);
    cyc(); settle();
    chk("t1_arvalid_hold", mem_axi_arvalid, 1'b1);
    chk("t1_araddr_hold", mem_axi_araddr, 32'h8000_0000);
    cyc(); mem_axi_arready = 1; settle();
    chk("t1_arvalid_hs", mem_axi_arvalid, 1'b1);
    cyc(); mem_axi_arready = 0; mem_axi_rvalid = 1; mem_axi_rdata = 32'h0000_0413; settle();
    chk("t1_arvalid_drop", mem_axi_arvalid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin cyc(); settle(); end
      chk("t1_stall_rready", mem_axi_rready, 1'b0);
      chk("t1_stall_rvalid", ifu_axi_rvalid, 1'b1);
      chk("t1_stall_rdata", ifu_axi_rdata, 32'h0000_0413);
    end
    cyc(); ifu_axi_rready = 1; settle();
    chk("t1_rready", mem_axi_rready, 1'b1);
    chk("t1_ifu_rvalid", ifu_axi_rvalid, 1'b1);
    chk("t1_ifu_rdata", ifu_axi_rdata, 32'h0000_0413);
    chk("t1_lsu_rvalid", lsu_axi_rvalid, 1'b0);
    cyc(); mem_axi_rvalid = 0; ifu_axi_rready = 0; settle();
    chk("t1_back_idle_rready", mem_axi_rready, 1'b1);
    chk("t1_back_idle_rvalid", ifu_axi_rvalid, 1'b0);

    // Both read in the same cycle with rr_last=LSU (fresh reset) -> IFU first
    cyc(); rst = 1; cyc(); rst = 0;
    ifu_axi_arvalid = 1; ifu_axi_araddr = 32'h8000_0004;
    lsu_axi_arvalid = 1; lsu_axi_araddr = 32'h8000_1000; settle();
    chk("t2_ifu_arready", ifu_axi_arready, 1'b1);
    chk("t2_lsu_arready", lsu_axi_arready, 1'b0);
    cyc(); ifu_axi_arvalid = 0; mem_axi_arready = 1; settle();
    chk("t2_araddr_ifu", mem_axi_araddr, 32'h8000_0004);
    chk("t2_arprot_ifu", mem_axi_arprot, 3'b100);
    chk("t2_lsu_arready_busy", lsu_axi_arready, 1'b0);
    cyc(); mem_axi_arready = 0; mem_axi_rvalid = 1; mem_axi_rdata = 32'h1111_1111;
    ifu_axi_rready = 1; settle();
    chk("t2_lsu_arready_rdata", lsu_axi_arready, 1'b0);
    chk("t2_ifu_rvalid", ifu_axi_rvalid, 1'b1);
    chk("t2_lsu_rvalid_non_owner", lsu_axi_rvalid, 1'b0);
    cyc(); mem_axi_rvalid = 0; ifu_axi_rready = 0; settle();
    chk("t2_lsu_arready_after", lsu_axi_arready, 1'b1);
    chk("t2_arvalid_not_early", mem_axi_arvalid, 1'b0);
    cyc(); lsu_axi_arvalid = 0; mem_axi_arready = 1; settle();
    chk("t2_araddr_lsu", mem_axi_araddr, 32'h8000_1000);
    chk("t2_arprot_lsu", mem_axi_arprot, 3'b000);
    cyc(); mem_axi_arready = 0; mem_axi_rvalid = 1; mem_axi_rdata = 32'h2222_2222;
    lsu_axi_rready = 1; settle();
    chk("t2_lsu_rvalid", lsu_axi_rvalid, 1'b1);
    chk("t2_lsu_rdata", lsu_axi_rdata, 32'h2222_2222);
    chk("t2_ifu_rvalid_non_owner", ifu_axi_rvalid, 1'b0);
    cyc(); mem_axi_rvalid = 0; lsu_axi_rready = 0; settle();

    // LSU write, wready one cycle before awready, IFU read pending meanwhile
    lsu_axi_awvalid = 1; lsu_axi_wvalid = 1; lsu_axi_awaddr = 32'ha000_03f8;
    lsu_axi_wdata = 32'h0000_0041; lsu_axi_wstrb = 4'b0001; settle();
    chk("t3_awready", lsu_axi_awready, 1'b1);
    chk("t3_wready", lsu_axi_wready, 1'b1);
    cyc(); lsu_axi_awvalid = 0; lsu_axi_wvalid = 0; lsu_axi_wdata = 32'hffff_ffff;
    ifu_axi_arvalid = 1; ifu_axi_araddr = 32'h8000_0008; mem_axi_wready = 1; settle();
    chk("t3_mem_awvalid", mem_axi_awvalid, 1'b1);
    chk("t3_mem_wvalid", mem_axi_wvalid, 1'b1);
    chk("t3_awaddr", mem_axi_awaddr, 32'ha000_03f8);
    chk("t3_wdata", mem_axi_wdata, 32'h0000_0041);
    chk("t3_wstrb", mem_axi_wstrb, 4'b0001);
    chk("t3_awprot", mem_axi_awprot, 3'b000);
    chk("t3_ifu_blocked_req", ifu_axi_arready, 1'b0);
    cyc(); mem_axi_wready = 0; mem_axi_awready = 1; settle();
    chk("t3_awvalid_hold", mem_axi_awvalid, 1'b1);
    chk("t3_wvalid_clear", mem_axi_wvalid, 1'b0);
    chk("t3_awaddr_hold", mem_axi_awaddr, 32'ha000_03f8);
    chk("t3_ifu_blocked_aw", ifu_axi_arready, 1'b0);
    cyc(); mem_axi_awready = 0; mem_axi_bvalid = 1; lsu_axi_bready = 1; settle();
    chk("t3_awvalid_clear", mem_axi_awvalid, 1'b0);
    chk("t3_lsu_bvalid", lsu_axi_bvalid, 1'b1);
    chk("t3_mem_bready", mem_axi_bready, 1'b1);
    chk("t3_ifu_blocked_b", ifu_axi_arready, 1'b0);
    chk("t3_no_arvalid", mem_axi_arvalid, 1'b0);
    cyc(); mem_axi_bvalid = 0; lsu_axi_bready = 0; settle();
    chk("t3_bvalid_once", lsu_axi_bvalid, 1'b0);
    chk("t3_ifu_granted", ifu_axi_arready, 1'b1);
    cyc(); ifu_axi_arvalid = 0; mem_axi_arready = 1; settle();
    chk("t3_ifu_araddr", mem_axi_araddr, 32'h8000_0008);
    cyc(); mem_axi_arready = 0; mem_axi_rvalid = 1; ifu_axi_rready = 1; settle();
    cyc(); mem_axi_rvalid = 0; ifu_axi_rready = 0; settle();

    // LSU write and IFU read in the same cycle -> write wins
    lsu_axi_awvalid = 1; lsu_axi_wvalid = 1; lsu_axi_awaddr = 32'ha000_0010;
    lsu_axi_wdata = 32'h1234_5678; lsu_axi_wstrb = 4'b1111;
    ifu_axi_arvalid = 1; ifu_axi_araddr = 32'h8000_000c; settle();
    chk("t4_awready", lsu_axi_awready, 1'b1);
    chk("t4_ifu_arready", ifu_axi_arready, 1'b0);
    cyc(); lsu_axi_awvalid = 0; lsu_axi_wvalid = 0;
    mem_axi_awready = 1; mem_axi_wready = 1; settle();
    chk("t4_wstrb", mem_axi_wstrb, 4'b1111);
    chk("t4_ifu_blocked_req", ifu_axi_arready, 1'b0);
    cyc(); mem_axi_awready = 0; mem_axi_wready = 0; settle();
    chk("t4_both_clear", {mem_axi_awvalid, mem_axi_wvalid}, 2'b00);
    chk("t4_ifu_blocked_wait", ifu_axi_arready, 1'b0);
    cyc(); mem_axi_bvalid = 1; lsu_axi_bready = 1; settle();
    chk("t4_ifu_blocked_b", ifu_axi_arready, 1'b0);
    cyc(); mem_axi_bvalid = 0; lsu_axi_bready = 0; settle();
    chk("t4_ifu_granted", ifu_axi_arready, 1'b1);
    cyc(); ifu_axi_arvalid = 0; settle();
    chk("t4_ifu_arvalid", mem_axi_arvalid, 1'b1);
    chk("t4_ifu_araddr", mem_axi_araddr, 32'h8000_000c);

    // Reset while the previous read waits for arready, then a fresh read
    // gets to RD_DATA and reset hits before rvalid; the late rvalid is drained.
    cyc(); rst = 1; settle();
    cyc(); rst = 0; settle();
    chk("t5_arvalid_after_rst", mem_axi_arvalid, 1'b0);
    ifu_axi_arvalid = 1; ifu_axi_araddr = 32'h8000_0010;
    cyc(); ifu_axi_arvalid = 0; mem_axi_arready = 1; settle();
    cyc(); mem_axi_arready = 0; ifu_axi_rready = 1; settle();
    chk("t5_in_rd_data", mem_axi_rready, 1'b1);
    chk("t5_arvalid_low", mem_axi_arvalid, 1'b0);
    cyc(); ifu_axi_rready = 0; rst = 1; settle();
    cyc(); rst = 0; mem_axi_rvalid = 1; mem_axi_rdata = 32'hbad0_bad0; settle();
    chk("t5_drain_rready", mem_axi_rready, 1'b1);
    chk("t5_no_ifu_rvalid", ifu_axi_rvalid, 1'b0);
    chk("t5_no_lsu_rvalid", lsu_axi_rvalid, 1'b0);
    chk("t5_no_replay", mem_axi_arvalid, 1'b0);
    cyc(); mem_axi_rvalid = 0; settle();
    chk("t5_idle_after", ifu_axi_rvalid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
